// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO pair.
// One radix-2 step per clock, then a sign-fix cycle that writes HI/LO and pulses done.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed, is_div, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_signed = ~op_i[0];
    assign is_div    = op_i[1];
    assign sign_a    = is_signed & src_a_i[WIDTH-1];
    assign sign_b    = is_signed & src_b_i[WIDTH-1];
    assign abs_a     = sign_a ? {WIDTH{1'b0}} - src_a_i : src_a_i;
    assign abs_b     = sign_b ? {WIDTH{1'b0}} - src_b_i : src_b_i;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, opnd_q};
    assign div_step   = div_diff[WIDTH]
                        ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_q_q ? {2*WIDTH{1'b0}} - acc_q : acc_q;
    assign quo_fix  = neg_q_q ? {WIDTH{1'b0}} - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_r_q ? {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]
                              : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    state_d  = StCalc;
                    cnt_d    = CntW'(WIDTH - 1);
                    is_div_d = is_div;
                    acc_d    = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
                    opnd_d   = is_div ? abs_b : abs_a;
                    neg_q_d  = sign_a ^ sign_b;
                    neg_r_d  = sign_a;
                    dbz_d    = is_div & (src_b_i == '0);
                end
            end
            StCalc: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    // A zero divisor leaves the dividend as remainder; quotient forced to all ones.
                    hi_d = rem_fix;
                    lo_d = dbz_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations, results checked
// by a scoreboard against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, act, expv);
        end
    endtask

    // Reference: {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sp;
        longint sa, sb;
        logic [63:0] up;
        int q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'd0: begin sp = sa * sb; return sp; end
            2'd1: begin up = {32'b0, a} * {32'b0, b}; return up; end
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 66'd1, 66'd0);
            end else begin
                chk("result", {2'b00, hi, lo}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    task automatic direct_write(input logic hw, input logic lw, input logic [W-1:0] wd);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = wd;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0; wdata = $urandom;
        if (hw) model_hi = wd;
        if (lw) model_lo = wd;
        chk("direct_write", {busy, done, hi, lo}, {2'b00, model_hi, model_lo});
    endtask

    // Full operation with per-edge checks; poke re-pulses start and MTHI/MTLO at E5.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hw, input logic lw, input logic [W-1:0] wd,
                          input bit poke);
        logic [63:0] res;
        res = ref_model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        hi_we = hw; lo_we = lw; wdata = wd;
        exp_q.push_back(res);
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        if (hw) model_hi = wd;
        if (lw) model_lo = wd;
        chk("accept", {busy, done, hi, lo}, {2'b10, model_hi, model_lo});
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            if (poke && i == 5) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (i <= W) begin
                chk("calc_hold", {busy, done, hi, lo}, {2'b10, model_hi, model_lo});
            end else begin
                model_hi = res[63:32];
                model_lo = res[31:0];
                chk("fix_edge", {busy, done, hi, lo}, {2'b01, model_hi, model_lo});
            end
        end
        @(posedge clk); #1;
        chk("done_clear", {busy, done, hi, lo}, {2'b00, model_hi, model_lo});
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        chk("reset_state", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        rst = 1'b0;

        direct_write(1'b1, 1'b0, 32'hDEAD_BEEF);
        direct_write(1'b0, 1'b1, 32'h1234_5678);
        direct_write(1'b1, 1'b1, 32'hA5A5_0F0F);

        run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, '0, 1'b0);
        chk("mult_neg", {2'b00, model_hi, model_lo}, {2'b00, 64'hFFFF_FFFF_FFFF_FFEB});
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b0, '0, 1'b0);
        run_op(2'd0, 32'd12345, 32'd678, 1'b0, 1'b0, '0, 1'b1);
        run_op(2'd2, 32'd1000, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);

        // Reset in the middle of CALC: everything clears at once and no done follows.
        direct_write(1'b1, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        start = 1'b1; op = 2'd1; src_a = 32'd99; src_b = 32'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_hi = '0;
        model_lo = '0;
        chk("async_reset", {busy, done, hi, lo}, 66'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (i % 8 == 0) chk("post_reset_idle", {busy, done, hi, lo}, 66'd0);
        end
        run_op(2'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, '0, 1'b0);

        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 4) == 0)
                direct_write(1'($urandom), 1'($urandom), $urandom);
            run_op(2'($urandom), pick(), pick(), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 66'(exp_q.size()), 66'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
